uart_tx_fifo: RTL
=================

# uart_tx_fifo

UART transmitter with a small byte FIFO, the transmit counterpart to the CPU's program-load receiver. It accepts bytes from the CPU side through a valid/ready handshake, buffers them, and serialises each as an 8N1 frame on `TX` at `Baudrate` clock cycles per bit. It streams results (accumulator, memory dumps) back to the host that loaded the program over `RX`.

## Interface
Parameters:
- `Baudrate`, 24: clock cycles per UART bit; legal range ≥ 2.
- `Depth`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Data`  in  8  byte to transmit; sampled when `Send && Ready`.
- `Send`  in  1  write strobe; one byte accepted per cycle while `Ready` is high.
- `Ready`  out  1  FIFO not full (count < `Depth`).
- `TX`  out  1  serial line, registered; idles high.
- `Busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `Overflow`  out  1  one-cycle pulse when `Send` is high and `Ready` is low; the byte is dropped.

## Operation
- FIFO: `Depth` × 8 storage, read/write pointers of log2(`Depth`) bits wrapping modulo `Depth`, plus a count of log2(`Depth`)+1 bits.
  - Push on `Send && Ready`.
  - Pop when the FSM loads a byte.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: `TX`=1. If the FIFO is non-empty, pop into the shift register, go to START, drive `TX`=0.
  - START: hold for `Baudrate` cycles, then go to DATA with `TX`=bit0.
  - DATA: 8 bits, LSB first, each held `Baudrate` cycles, with a 3-bit bit index. After bit7 go to PARITY if it is compiled in, otherwise STOP.
  - STOP: `TX`=1 for `Baudrate` cycles. Then:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter counts 0..`Baudrate`-1, is cleared on every state entry, and advances the bit at terminal count.
- `Busy` = (state ≠ IDLE) || (count ≠ 0).
- The FIFO never pops while the FSM is mid-frame.

## Timing
- Reset values: `TX`=1, `Ready`=1, `Busy`=0, `Overflow`=0, state IDLE, pointers and count 0, baud counter 0.
- Reset is asynchronous.
  - Assertion mid-frame forces `TX`=1 immediately and discards FIFO contents and the frame in flight.
  - The first frame after deassertion starts no earlier than the first edge that sees a non-empty FIFO.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE drives `TX` low at edge k+1.
- Frame length: 10×`Baudrate` cycles (11×`Baudrate` with parity). Back-to-back frames are contiguous.
- `Ready` deasserts the cycle after the count reaches `Depth`. It reasserts the cycle after the pop that frees an entry.
- Push while full is not accepted even if a pop occurs on the same edge; `Overflow` pulses for that cycle.
- `Busy` falls on the edge the FSM enters IDLE with the FIFO empty.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: PARITY state inserted between DATA and STOP. `TX` = XOR of the 8 data bits (even parity) for `Baudrate` cycles. Frame is 11 bits.
  - Undefined: the PARITY state and its logic are absent. Frame is 8N1, 10 bits.

## Test plan
- Reset mid-frame: assert `Reset` during DATA of 0x3C with 2 bytes queued → `TX`=1 asynchronously, `Busy`=0, `Ready`=1. After release, no further frames appear.
- Single byte (`Baudrate`=24, no parity): `Send` 0xA5 for one cycle → `TX` falls 1 cycle later. Bit sequence is 0,1,0,1,0,0,1,0,1,1, each held exactly 24 cycles. `Busy` is high for 240 cycles.
- Back-to-back: queue 0x00 then 0xFF → two contiguous frames with no idle cycle. Total `Busy` time is 480 cycles.
- Fill/overflow (`Depth`=4): hold `Send` 6 consecutive cycles with 0x01..0x06.
  - 0x01..0x05 are accepted (first pop overlaps second push).
  - `Ready`=0 on cycle 6; 0x06 is dropped with `Overflow` pulsing once.
  - Line carries 01, 02, 03, 04, 05 in order.
- Pointer wrap: stream 9 bytes, refilling whenever `Ready`=1 → all 9 are transmitted in order with no `Overflow`.
- Parity build (`UART_TX_PARITY_EN` defined): send 0x07 → parity bit 1. Send 0x03 → parity bit 0. Frame is 264 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO behind a valid/ready push port, serialised as 8N1 frames on TX.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int Baudrate = 24,
    parameter int Depth    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Data,
    input  logic       Send,
    output logic       Ready,
    output logic       TX,
    output logic       Busy,
    output logic       Overflow
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (Baudrate > 1) ? $clog2(Baudrate) : 1;

    localparam logic [CW-1:0] FullCount = CW'(Depth);
    localparam logic [BW-1:0] BaudLast  = BW'(Baudrate - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t         state;
    logic [7:0]     mem [Depth];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     frame_byte;
    logic           push;
    logic           pop;
    logic           baud_last;
    logic [7:0]     fifo_head;

    assign Ready     = (count != FullCount);
    assign push      = Send && Ready;
    assign Overflow  = Send && !Ready;
    assign Busy      = (state != IDLE) || (count != '0);
    assign baud_last = (baud_cnt == BaudLast);
    assign fifo_head = mem[rd_ptr];

    // A byte leaves the FIFO only at a frame boundary: from IDLE, or at the end of a stop bit.
    assign pop = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_last));

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= Data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Baud counter restarts on every state entry; TX is registered alongside the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            frame_byte <= '0;
            TX         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    TX       <= 1'b1;
                    if (pop) begin
                        frame_byte <= fifo_head;
                        state      <= START;
                        TX         <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        TX       <= frame_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            TX    <= ^frame_byte;
`else
                            state <= STOP;
                            TX    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TX      <= frame_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        TX       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            frame_byte <= fifo_head;
                            state      <= START;
                            TX         <= 1'b0;
                        end else begin
                            state <= IDLE;
                            TX    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    TX       <= 1'b1;
                end
            endcase
        end
    end

endmodule
